dca_lsu_inst_arbiter: RTL and testbench
=======================================

// Module: dca_lsu_inst_arbiter
// PURPOSE
//  Shares one memory-side LSU instruction port between NUM_REQ matrix load/store instruction issuers
//  (e.g. the A/B/C load sequencers and the store sequencer of a DCA MAC tile).
//  Round-robin arbitration feeds a one-stage registered output with a valid/ready handshake.
//  Per-requester outstanding counters throttle issue and route LSU completions back as per-requester done pulses.
// PARAMETERS
//  NUM_REQ          3                          number of requesters, 2..8
//  BW_INST          `BW_DCA_MATRIX_LSU_INST    LSU instruction width
//  MAX_OUTSTANDING  2                          max issued-but-not-done instructions per requester, >=1
//  (local) BW_ID = clog2(NUM_REQ); BW_CNT = clog2(MAX_OUTSTANDING+1)
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  reset, asynchronous, active-high
//  clear        in   1                  synchronous abort/flush
//  enable       in   1                  0: no new grants; a held output stays valid
//  req_valid    in   NUM_REQ            per-requester instruction valid
//  req_ready    out  NUM_REQ            per-requester accept (one-hot or zero)
//  req_inst     in   NUM_REQ*BW_INST    slot i at [i*BW_INST +: BW_INST]
//  req_done     out  NUM_REQ            per-requester completion pulse
//  lsu_valid    out  1                  output instruction valid
//  lsu_ready    in   1                  LSU accepts the output instruction
//  lsu_inst     out  BW_INST            output instruction
//  lsu_id       out  BW_ID              index of the requester that owns lsu_inst
//  lsu_done     in   1                  LSU completion strobe
//  lsu_done_id  in   BW_ID              requester index of the completion
//  busy         out  1                  lsu_valid | any outstanding counter != 0
//  err          out  1                  sticky: done with count==0 or id>=NUM_REQ
// BEHAVIOUR
//  - Reset: lsu_valid, lsu_inst, lsu_id, req_done, err, all counters = 0.
//    Priority pointer set so requester 0 wins first. req_ready = 0 and busy = 0 while rst is high.
//  - Output stage: states EMPTY (lsu_valid=0) and HOLD (lsu_valid=1).
//    HOLD->EMPTY on lsu_valid&lsu_ready with no new grant.
//    EMPTY->HOLD on a grant.
//    HOLD->HOLD on a grant in the same cycle as the output handshake (1 instr/cycle throughput).
//  - slot_free = !lsu_valid | lsu_ready.
//  - eligible[i] = req_valid[i] & (cnt[i] < MAX_OUTSTANDING).
//  - Grant g is the first eligible index scanning from last_grant+1 with wrap-around.
//    It is issued only when enable & !clear & slot_free.
//  - req_ready[g] = 1 combinationally in the grant cycle; all other req_ready bits = 0.
//  - On grant: next cycle lsu_valid=1, lsu_inst=req_inst[g], lsu_id=g, last_grant=g.
//    Latency from grant to lsu_valid is 1 cycle.
//  - While HOLD and !lsu_ready: lsu_inst and lsu_id are stable and req_ready = 0.
//    enable=0 never drops a held lsu_valid.
//  - Counters: cnt[g]++ on grant; cnt[d]-- on a valid lsu_done with d=lsu_done_id.
//    Grant and done on the same index in one cycle leave cnt unchanged.
//    Eligibility uses the pre-update cnt.
//  - Valid done (d<NUM_REQ and cnt[d]>0): req_done[d] pulses for exactly 1 cycle, in the cycle after lsu_done.
//  - Invalid done: no decrement and no pulse; err is set to 1 the next cycle and held.
//  - Counters saturate and never wrap. Increment at MAX cannot occur because eligibility gates it.
//  - clear (1 cycle) takes effect at the next edge:
//    lsu_valid=0, counters=0, err=0, pointer back to reset value.
//    lsu_done is ignored and req_ready=0 during the clear cycle.
//    An un-accepted held instruction is discarded.
//  - rst asserted mid-transfer returns all state to reset values immediately (asynchronous).
// TESTING
//  1. req_valid=3'b010, slot1=0xA5, lsu_ready=1 at cycle 0 ->
//     req_ready=3'b010 at cycle 0; lsu_valid=1, lsu_inst=0xA5, lsu_id=1 at cycle 1.
//  2. req_valid=3'b111 held, lsu_ready=1, done returned each cycle ->
//     lsu_id sequence 0,1,2,0,1,2 with lsu_valid continuously 1.
//  3. lsu_valid=1 (id 2, inst 0x3C), lsu_ready=0 for 5 cycles with all req_valid=1 ->
//     lsu_inst=0x3C and lsu_id=2 stable; req_ready=0 throughout.
//  4. MAX_OUTSTANDING=2: requester 0 alone issues 2, no done -> third request not granted.
//     Requester 1 is granted when valid. lsu_done id0 -> req_done=3'b001 next cycle, requester 0 eligible again.
//  5. cnt[0]=1, grant to 0 and lsu_done id0 in the same cycle -> cnt[0] stays 1, req_done[0] pulses.
//     Then lsu_done id3 -> err=1 sticky; busy follows the counters.
//  6. clear while lsu_valid=1 and cnt=(1,2,0) -> next cycle lsu_valid=0, busy=0, err=0.
//     The next grant with all req_valid=1 goes to requester 0.

Source files
------------

// File: rtl/dca_lsu_inst_arbiter.sv
// Round-robin arbiter sharing one LSU instruction port between NUM_REQ issuers,
// with a one-entry registered output stage and per-requester outstanding tracking.
`ifndef BW_DCA_MATRIX_LSU_INST
`define BW_DCA_MATRIX_LSU_INST 64
`endif

module dca_lsu_inst_arbiter #(
   parameter  int NUM_REQ         = 3,
   parameter  int BW_INST         = `BW_DCA_MATRIX_LSU_INST,
   parameter  int MAX_OUTSTANDING = 2,
   localparam int BW_ID           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
   localparam int BW_CNT          = $clog2(MAX_OUTSTANDING + 1)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       enable,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*BW_INST-1:0] req_inst,
   output logic [NUM_REQ-1:0]         req_done,
   output logic                       lsu_valid,
   input  logic                       lsu_ready,
   output logic [BW_INST-1:0]         lsu_inst,
   output logic [BW_ID-1:0]           lsu_id,
   input  logic                       lsu_done,
   input  logic [BW_ID-1:0]           lsu_done_id,
   output logic                       busy,
   output logic                       err
);

   typedef enum logic {EMPTY, HOLD} state_t;

   localparam logic [BW_ID-1:0]  FIRST_PTR = BW_ID'(NUM_REQ - 1);
   localparam logic [BW_CNT-1:0] CNT_MAX   = BW_CNT'(MAX_OUTSTANDING);

   state_t               state;
   logic [BW_ID-1:0]     last_grant;
   logic [BW_CNT-1:0]    cnt [NUM_REQ];

   logic [NUM_REQ-1:0]   eligible;
   logic                 slot_free;
   logic                 hi_any, lo_any, grant_any, grant_fire;
   logic [BW_ID-1:0]     hi_id, lo_id, grant_id;
   logic [NUM_REQ-1:0]   grant_vec;
   logic [BW_INST-1:0]   grant_inst;
   logic [NUM_REQ-1:0]   done_vec;
   logic                 done_bad;
   logic                 cnt_any;

   assign lsu_valid = (state == HOLD);
   assign slot_free = !lsu_valid || lsu_ready;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      eligible = '0;
      cnt_any  = 1'b0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i] = req_valid[i] && (cnt[i] < CNT_MAX);
         cnt_any     = cnt_any || (cnt[i] != '0);
      end
   end

   // Lowest eligible index above the last grant wins; otherwise wrap to the lowest overall.
   always_comb begin
      hi_any = 1'b0;
      hi_id  = '0;
      lo_any = 1'b0;
      lo_id  = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (eligible[i]) begin
            if (i > int'(last_grant)) begin
               hi_any = 1'b1;
               hi_id  = BW_ID'(i);
            end else begin
               lo_any = 1'b1;
               lo_id  = BW_ID'(i);
            end
         end
      end
      grant_any = hi_any || lo_any;
      grant_id  = hi_any ? hi_id : lo_id;
   end

   assign grant_fire = grant_any && enable && !clear && slot_free && !rst;

   always_comb begin
      grant_vec  = '0;
      grant_inst = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant_fire && (grant_id == BW_ID'(i))) begin
            grant_vec[i] = 1'b1;
            grant_inst   = req_inst[i*BW_INST +: BW_INST];
         end
      end
   end

   assign req_ready = grant_vec;

   // A completion is valid only for an in-range requester that has something outstanding.
   always_comb begin
      done_vec = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (lsu_done && !clear && (lsu_done_id == BW_ID'(i)) && (cnt[i] != '0))
            done_vec[i] = 1'b1;
      end
      done_bad = lsu_done && !clear && (done_vec == '0);
   end

   assign busy = !rst && (lsu_valid || cnt_any);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= EMPTY;
         lsu_inst   <= '0;
         lsu_id     <= '0;
         last_grant <= FIRST_PTR;
         req_done   <= '0;
         err        <= 1'b0;
      end else if (clear) begin
         state      <= EMPTY;
         last_grant <= FIRST_PTR;
         req_done   <= '0;
         err        <= 1'b0;
      end else begin
         if (grant_fire) begin
            state      <= HOLD;
            lsu_inst   <= grant_inst;
            lsu_id     <= grant_id;
            last_grant <= grant_id;
         end else if (lsu_valid && lsu_ready) begin
            state <= EMPTY;
         end
         req_done <= done_vec;
         if (done_bad)
            err <= 1'b1;
      end
   end

   // NOTE: the counter array is reset like any flop; busy and eligibility read it from the first cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REQ; i++)
            cnt[i] <= '0;
      end else if (clear) begin
         for (int i = 0; i < NUM_REQ; i++)
            cnt[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_vec[i] && !done_vec[i] && (cnt[i] != CNT_MAX))
               cnt[i] <= cnt[i] + 1'b1;
            else if (done_vec[i] && !grant_vec[i] && (cnt[i] != '0))
               cnt[i] <= cnt[i] - 1'b1;
         end
      end
   end

`ifndef SYNTHESIS
   a_ready_onehot : assert property (@(posedge clk) disable iff (rst) $onehot0(req_ready));
   a_hold_stable  : assert property (@(posedge clk) disable iff (rst || clear)
                       (lsu_valid && !lsu_ready) |=> (lsu_valid && $stable(lsu_inst) && $stable(lsu_id)));
`endif

endmodule

// File: tb/tb_dca_lsu_inst_arbiter.sv
// Table-driven bench for dca_lsu_inst_arbiter with a scoreboard on the LSU output handshake.
module tb_dca_lsu_inst_arbiter;

   localparam int NUM_REQ = 3;
   localparam int BW_INST = 8;
   localparam int MAX_OUT = 2;
   localparam int BW_ID   = 2;

   logic                       clk = 1'b0;
   logic                       rst;
   logic                       clear;
   logic                       enable;
   logic [NUM_REQ-1:0]         req_valid;
   logic [NUM_REQ-1:0]         req_ready;
   logic [NUM_REQ*BW_INST-1:0] req_inst;
   logic [NUM_REQ-1:0]         req_done;
   logic                       lsu_valid;
   logic                       lsu_ready;
   logic [BW_INST-1:0]         lsu_inst;
   logic [BW_ID-1:0]           lsu_id;
   logic                       lsu_done;
   logic [BW_ID-1:0]           lsu_done_id;
   logic                       busy;
   logic                       err;

   always #5 clk = ~clk;

   dca_lsu_inst_arbiter #(
      .NUM_REQ(NUM_REQ), .BW_INST(BW_INST), .MAX_OUTSTANDING(MAX_OUT)
   ) dut (
      .clk(clk), .rst(rst), .clear(clear), .enable(enable),
      .req_valid(req_valid), .req_ready(req_ready), .req_inst(req_inst), .req_done(req_done),
      .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_inst(lsu_inst), .lsu_id(lsu_id),
      .lsu_done(lsu_done), .lsu_done_id(lsu_done_id), .busy(busy), .err(err)
   );

   typedef struct {
      logic [2:0] rv;
      logic       rdy;
      logic       en;
      logic       clr;
      logic       dn;
      logic [1:0] did;
      logic [2:0] exp_rr;
      logic       exp_valid;
      logic [1:0] exp_id;
      logic [2:0] exp_done;
      logic       exp_busy;
      logic       exp_err;
   } vec_t;

   typedef struct {
      logic [7:0] inst;
      logic [1:0] id;
   } sb_t;

   vec_t       vecs[$];
   sb_t        sb[$];
   logic [7:0] slot_val [NUM_REQ] = '{8'h11, 8'hA5, 8'h3C};
   int         checks = 0;
   int         errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [2:0] rv, input logic rdy, input logic en,
                               input logic clr, input logic dn, input logic [1:0] did,
                               input logic [2:0] exp_rr, input logic exp_valid,
                               input logic [1:0] exp_id, input logic [2:0] exp_done,
                               input logic exp_busy, input logic exp_err);
      vec_t v;
      v.rv = rv; v.rdy = rdy; v.en = en; v.clr = clr; v.dn = dn; v.did = did;
      v.exp_rr = exp_rr; v.exp_valid = exp_valid; v.exp_id = exp_id;
      v.exp_done = exp_done; v.exp_busy = exp_busy; v.exp_err = exp_err;
      return v;
   endfunction

   // Every accepted output instruction must match the oldest grant the bench expects.
   always @(negedge clk) begin
      if (!rst && !clear && lsu_valid && lsu_ready) begin
         if (sb.size() == 0) begin
            check("sb_unexpected_handshake", 32'(lsu_id), 32'hFF);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("sb_inst", 32'(lsu_inst), 32'(e.inst));
            check("sb_id", 32'(lsu_id), 32'(e.id));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst         = 1'b1;
      clear       = 1'b0;
      enable      = 1'b1;
      req_valid   = 3'b111;
      lsu_ready   = 1'b1;
      lsu_done    = 1'b0;
      lsu_done_id = '0;
      req_inst    = {slot_val[2], slot_val[1], slot_val[0]};

      // rv    rdy en clr dn did  exp_rr v  id done  busy err
      vecs.push_back(mk(3'b010, 1, 1, 0, 0, 0, 3'b010, 1, 1, 3'b000, 1, 0));
      vecs.push_back(mk(3'b111, 1, 1, 0, 1, 1, 3'b100, 1, 2, 3'b010, 1, 0));
      vecs.push_back(mk(3'b111, 1, 1, 0, 1, 2, 3'b001, 1, 0, 3'b100, 1, 0));
      vecs.push_back(mk(3'b111, 1, 1, 0, 1, 0, 3'b010, 1, 1, 3'b001, 1, 0));
      vecs.push_back(mk(3'b111, 1, 1, 0, 1, 1, 3'b100, 1, 2, 3'b010, 1, 0));
      vecs.push_back(mk(3'b111, 1, 1, 0, 1, 2, 3'b001, 1, 0, 3'b100, 1, 0));
      vecs.push_back(mk(3'b111, 1, 1, 0, 1, 0, 3'b010, 1, 1, 3'b001, 1, 0));
      vecs.push_back(mk(3'b111, 1, 1, 0, 1, 1, 3'b100, 1, 2, 3'b010, 1, 0));
      // held output under backpressure, enable low must not drop it
      vecs.push_back(mk(3'b111, 0, 1, 0, 0, 0, 3'b000, 1, 2, 3'b000, 1, 0));
      vecs.push_back(mk(3'b111, 0, 1, 0, 0, 0, 3'b000, 1, 2, 3'b000, 1, 0));
      vecs.push_back(mk(3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 2, 3'b000, 1, 0));
      vecs.push_back(mk(3'b111, 0, 0, 0, 0, 0, 3'b000, 1, 2, 3'b000, 1, 0));
      vecs.push_back(mk(3'b111, 0, 1, 0, 0, 0, 3'b000, 1, 2, 3'b000, 1, 0));
      vecs.push_back(mk(3'b000, 1, 1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0));
      vecs.push_back(mk(3'b000, 1, 1, 0, 1, 2, 3'b000, 0, 0, 3'b100, 0, 0));
      vecs.push_back(mk(3'b111, 1, 0, 0, 0, 0, 3'b000, 0, 0, 3'b000, 0, 0));
      // outstanding limit on requester 0
      vecs.push_back(mk(3'b001, 1, 1, 0, 0, 0, 3'b001, 1, 0, 3'b000, 1, 0));
      vecs.push_back(mk(3'b001, 1, 1, 0, 0, 0, 3'b001, 1, 0, 3'b000, 1, 0));
      vecs.push_back(mk(3'b001, 1, 1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0));
      vecs.push_back(mk(3'b011, 1, 1, 0, 0, 0, 3'b010, 1, 1, 3'b000, 1, 0));
      vecs.push_back(mk(3'b001, 1, 1, 0, 1, 0, 3'b000, 0, 0, 3'b001, 1, 0));
      vecs.push_back(mk(3'b001, 1, 1, 0, 0, 0, 3'b001, 1, 0, 3'b000, 1, 0));
      // simultaneous grant and done on one index, then bad completions
      vecs.push_back(mk(3'b000, 1, 1, 0, 1, 0, 3'b000, 0, 0, 3'b001, 1, 0));
      vecs.push_back(mk(3'b001, 1, 1, 0, 1, 0, 3'b001, 1, 0, 3'b001, 1, 0));
      vecs.push_back(mk(3'b000, 1, 1, 0, 1, 3, 3'b000, 0, 0, 3'b000, 1, 1));
      vecs.push_back(mk(3'b000, 1, 1, 0, 1, 1, 3'b000, 0, 0, 3'b010, 1, 1));
      vecs.push_back(mk(3'b000, 1, 1, 0, 1, 0, 3'b000, 0, 0, 3'b001, 0, 1));
      vecs.push_back(mk(3'b000, 1, 1, 0, 1, 0, 3'b000, 0, 0, 3'b000, 0, 1));
      // build cnt=(1,2,0) with a held output, then clear
      vecs.push_back(mk(3'b011, 0, 1, 0, 0, 0, 3'b010, 1, 1, 3'b000, 1, 1));
      vecs.push_back(mk(3'b011, 1, 1, 0, 0, 0, 3'b001, 1, 0, 3'b000, 1, 1));
      vecs.push_back(mk(3'b010, 1, 1, 0, 0, 0, 3'b010, 1, 1, 3'b000, 1, 1));
      vecs.push_back(mk(3'b010, 0, 1, 0, 0, 0, 3'b000, 1, 1, 3'b000, 1, 1));
      vecs.push_back(mk(3'b111, 0, 1, 1, 1, 1, 3'b000, 0, 0, 3'b000, 0, 0));
      vecs.push_back(mk(3'b111, 1, 1, 0, 0, 0, 3'b001, 1, 0, 3'b000, 1, 0));
      vecs.push_back(mk(3'b000, 1, 1, 0, 0, 0, 3'b000, 0, 0, 3'b000, 1, 0));
      vecs.push_back(mk(3'b000, 1, 1, 0, 1, 0, 3'b000, 0, 0, 3'b001, 0, 0));

      // reset state
      #1;
      check("rst_req_ready", 32'(req_ready), 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_lsu_valid", 32'(lsu_valid), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      tick();
      tick();
      req_valid = 3'b000;
      rst       = 1'b0;
      #1;
      check("post_rst_lsu_id", 32'(lsu_id), 32'h0);
      check("post_rst_req_done", 32'(req_done), 32'h0);
      check("post_rst_busy", 32'(busy), 32'h0);

      for (int n = 0; n < vecs.size(); n++) begin
         vec_t v;
         v = vecs[n];
         req_valid   = v.rv;
         lsu_ready   = v.rdy;
         enable      = v.en;
         clear       = v.clr;
         lsu_done    = v.dn;
         lsu_done_id = v.did;
         if (v.clr)
            sb.delete();
         #1;
         check($sformatf("v%0d_req_ready", n), 32'(req_ready), 32'(v.exp_rr));
         for (int i = 0; i < NUM_REQ; i++) begin
            if (v.exp_rr[i])
               sb.push_back('{slot_val[i], 2'(i)});
         end
         tick();
         check($sformatf("v%0d_lsu_valid", n), 32'(lsu_valid), 32'(v.exp_valid));
         if (v.exp_valid)
            check($sformatf("v%0d_lsu_id", n), 32'(lsu_id), 32'(v.exp_id));
         check($sformatf("v%0d_req_done", n), 32'(req_done), 32'(v.exp_done));
         check($sformatf("v%0d_busy", n), 32'(busy), 32'(v.exp_busy));
         check($sformatf("v%0d_err", n), 32'(err), 32'(v.exp_err));
      end
      clear    = 1'b0;
      enable   = 1'b1;
      lsu_done = 1'b0;

      // asynchronous reset while an instruction is held and err is set
      req_valid   = 3'b010;
      lsu_ready   = 1'b0;
      lsu_done    = 1'b1;
      lsu_done_id = 2'd3;
      #1;
      check("mid_req_ready", 32'(req_ready), 32'h2);
      tick();
      check("mid_hold_id", 32'(lsu_id), 32'h1);
      check("mid_err", 32'(err), 32'h1);
      lsu_done  = 1'b0;
      req_valid = 3'b111;
      tick();
      #2;
      rst = 1'b1;
      #1;
      sb.delete();
      check("async_lsu_valid", 32'(lsu_valid), 32'h0);
      check("async_busy", 32'(busy), 32'h0);
      check("async_err", 32'(err), 32'h0);
      check("async_req_ready", 32'(req_ready), 32'h0);
      check("async_lsu_id", 32'(lsu_id), 32'h0);
      tick();
      rst       = 1'b0;
      lsu_ready = 1'b1;
      #1;
      check("after_rst_req_ready", 32'(req_ready), 32'h1);
      sb.push_back('{slot_val[0], 2'd0});
      tick();
      check("after_rst_lsu_valid", 32'(lsu_valid), 32'h1);
      check("after_rst_lsu_id", 32'(lsu_id), 32'h0);
      req_valid = 3'b000;
      tick();
      tick();
      check("sb_drained", 32'(sb.size()), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
